mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, word address width; DATA_W, default 32, data width; LAT, default 2, memory read latency in cycles (legal 1..7); FAIRNESS, default 3, max consecutive data grants while a fetch waits.
REQ-002 Ports SHALL be:
clk  in  1  sole clock, all state on posedge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request accepted this cycle
if_valid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_W  fetch data
d_req  in  1  data-stage request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_valid  out  1  load data valid / store done, one-cycle pulse
d_rdata  out  DATA_W  load data
mem_en  out  1  single-port memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid LAT cycles after mem_en
stall_if  out  1  hold PC and IF/ID register
stall_mem  out  1  hold EX/MEM and earlier stages
REQ-003 The clock SHALL be named clk and the reset rst; one clock, reset synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, BUSY, RESP; at most one access outstanding.
REQ-005 In IDLE, d_req SHALL win over if_req, except when the fairness counter equals FAIRNESS and if_req is high, in which case fetch SHALL win.
REQ-006 Grant (cycle T) SHALL assert the winner's gnt combinationally, drive mem_en=1, mem_addr/mem_we/mem_wdata from the winner (mem_we=0 for fetch), latch owner, and enter BUSY with latency counter = LAT-1.
REQ-007 Fairness counter SHALL increment on a data grant while if_req is high, saturate at FAIRNESS, and clear on any fetch grant or when if_req is low.
REQ-008 In BUSY, mem_en SHALL be 0; counter decrements; when counter is 0 the block SHALL register mem_rdata (cycle T+LAT) and enter RESP.
REQ-009 In RESP (cycle T+LAT+1) the owner's valid SHALL pulse for exactly one cycle with rdata = registered value; rdata SHALL hold until the next response for that port.
REQ-010 A store SHALL follow the same timing; d_valid pulses at T+LAT+1, d_rdata unchanged.
REQ-011 RESP SHALL behave as IDLE for arbitration, so a new grant may issue in the same cycle as valid; sustained throughput = one access per LAT+1 cycles.
REQ-012 Requests are level-sensitive; a request is consumed at gnt; requester SHALL hold req low from T+1 until its valid; req high in other states SHALL be ignored and not consumed.
REQ-013 stall_if SHALL = (if_req & ~if_gnt) | (fetch outstanding & ~if_valid); stall_mem likewise for the data port.
REQ-014 Simultaneous requests in RESP SHALL be arbitrated per REQ-005 using the updated fairness counter.

Reset
REQ-015 While rst is high at posedge: state <- IDLE, counters <- 0, owner cleared, registered rdata <- 0; gnt, valid, mem_en, mem_we low; stall outputs follow REQ-013 with no access outstanding.
REQ-016 Reset mid-access SHALL abandon the access with no valid pulse; a store already strobed is not undone.

Structure
REQ-017 A shared package cpu_mem_pkg SHALL hold the state enum, owner encoding (FETCH/DATA) and default width/latency constants.
REQ-018 One sub-module, lat_counter (load, decrement, zero flag), is natural; arbitration stays in mem_port_arbiter.

Verification (LAT=2, FAIRNESS=3)
REQ-019 Fetch only: if_req, if_addr=5, mem[5]=32'hDEAD_BEEF at T -> if_gnt at T, mem_en at T, if_valid with 32'hDEAD_BEEF at T+3, stall_if high T..T+2.
REQ-020 Both request at T, d_addr=8 load -> d_gnt at T, d_valid at T+3; if_gnt at T+3, if_valid at T+6.
REQ-021 Store d_we=1, d_addr=4, d_wdata=7, then load addr 4 -> mem_we=1 at grant, load returns 7.
REQ-022 Fairness: d_req and if_req held continuously -> grants D,D,D,F,D,D,D,F.
REQ-023 rst asserted at T+1 during fetch -> no if_valid at T+3, state IDLE at T+2, fresh request granted at T+2.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the CPU memory-port arbiter slice.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LAT      = 2;
    localparam int DEF_FAIRNESS = 3;
    localparam int LAT_CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    // A grant is followed by LAT-1 further wait cycles before the read data lands.
    function automatic logic [LAT_CNT_W-1:0] lat_preload(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Down-counter for memory read latency: load on grant, count down while busy.
module lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory, one access in flight.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LAT      = DEF_LAT,
    parameter int FAIRNESS = DEF_FAIRNESS
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem
);

    localparam int FAIR_W = (FAIRNESS < 1) ? 1 : $clog2(FAIRNESS + 1);

    arb_state_t        state_reg;
    owner_t            owner_reg;
    logic              owner_we_reg;
    logic [FAIR_W-1:0] fair_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic arb_ok;
    logic fair_full;
    logic fetch_wins;
    logic grant_f;
    logic grant_d;
    logic any_grant;
    logic resp_now;
    logic lat_zero;
    logic fetch_out;
    logic data_out;

    // RESP arbitrates exactly like IDLE so a new access can start alongside the valid pulse.
    assign arb_ok     = ((state_reg == IDLE) || (state_reg == RESP)) && !rst;
    assign fair_full  = (fair_reg == FAIR_W'(FAIRNESS));
    assign fetch_wins = if_req && (!d_req || fair_full);
    assign grant_f    = arb_ok && fetch_wins;
    assign grant_d    = arb_ok && d_req && !fetch_wins;
    assign any_grant  = grant_f || grant_d;

    assign if_gnt    = grant_f;
    assign d_gnt     = grant_d;
    assign mem_en    = any_grant;
    assign mem_we    = grant_d && d_we;
    assign mem_addr  = grant_f ? if_addr : d_addr;
    assign mem_wdata = d_wdata;

    assign resp_now = (state_reg == RESP) && !rst;
    assign if_valid = resp_now && (owner_reg == FETCH);
    assign d_valid  = resp_now && (owner_reg == DATA);
    assign if_rdata = if_rdata_reg;
    assign d_rdata  = d_rdata_reg;

    // An access counts as outstanding from its grant cycle until its valid pulse.
    assign fetch_out = grant_f || (!rst && (state_reg != IDLE) && (owner_reg == FETCH));
    assign data_out  = grant_d || (!rst && (state_reg != IDLE) && (owner_reg == DATA));
    assign stall_if  = (if_req && !if_gnt) || (fetch_out && !if_valid);
    assign stall_mem = (d_req && !d_gnt) || (data_out && !d_valid);

    lat_counter #(
        .W (LAT_CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (any_grant),
        .load_val (lat_preload(LAT)),
        .dec      (state_reg == BUSY),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= FETCH;
            owner_we_reg <= 1'b0;
            fair_reg     <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            // Fairness only accumulates while a fetch is actually waiting.
            if (!if_req || grant_f) begin
                fair_reg <= '0;
            end else if (grant_d && !fair_full) begin
                fair_reg <= fair_reg + 1'b1;
            end

            case (state_reg)
                IDLE, RESP: begin
                    if (any_grant) begin
                        state_reg    <= BUSY;
                        owner_reg    <= grant_d ? DATA : FETCH;
                        owner_we_reg <= grant_d && d_we;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    if (lat_zero) begin
                        state_reg <= RESP;
                        if (owner_reg == FETCH) begin
                            if_rdata_reg <= mem_rdata;
                        end else if (!owner_we_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter checked cycle-by-cycle against a timing/priority model.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int LAT      = 2;
    localparam int FAIRNESS = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall_if, stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LAT      (LAT),
        .FAIRNESS (FAIRNESS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory behaviour: data appears LAT cycles after the strobe.
    logic [DATA_W-1:0] mem_array [0:1023];
    logic [DATA_W-1:0] rd_pipe   [0:LAT];

    task automatic mem_step();
        for (int i = LAT; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = '0;
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr] = mem_wdata;
            else        rd_pipe[0] = mem_array[mem_addr];
        end
        mem_rdata = rd_pipe[LAT];
    endtask

    // Reference model: a single in-flight access, next arbitration at grant+LAT+1.
    logic [DATA_W-1:0] ref_mem [0:1023];
    int                cyc = 0;
    int                free_at = 0;
    int                fair = 0;
    int                txn_no = 0;
    bit                pend = 0;
    bit                pend_data_port = 0;
    bit                pend_we = 0;
    int                pend_cyc = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [DATA_W-1:0] pend_data = '0;
    logic [DATA_W-1:0] exp_if_rdata = '0;
    logic [DATA_W-1:0] exp_d_rdata = '0;
    bit last_fg = 0, last_dg = 0, last_iv = 0, last_dv = 0, last_rst = 0;
    bit obs_if_gnt = 0, obs_d_gnt = 0;

    task automatic model_step();
        bit e_fg, e_dg, e_iv, e_dv, force_f, fout, dout;
        if (rst) begin
            check_eq("rst_if_gnt", if_gnt, 0);
            check_eq("rst_d_gnt", d_gnt, 0);
            check_eq("rst_if_valid", if_valid, 0);
            check_eq("rst_d_valid", d_valid, 0);
            check_eq("rst_mem_en", mem_en, 0);
            check_eq("rst_mem_we", mem_we, 0);
            check_eq("rst_stall_if", stall_if, if_req);
            check_eq("rst_stall_mem", stall_mem, d_req);
            pend = 0; fair = 0; free_at = cyc + 1;
            exp_if_rdata = '0; exp_d_rdata = '0;
            last_fg = 0; last_dg = 0; last_iv = 0; last_dv = 0; last_rst = 1;
            cyc++;
            return;
        end
        e_iv    = pend && (pend_cyc == cyc) && !pend_data_port;
        e_dv    = pend && (pend_cyc == cyc) && pend_data_port;
        force_f = (fair == FAIRNESS) && if_req;
        e_dg    = (cyc >= free_at) && d_req && !force_f;
        e_fg    = (cyc >= free_at) && if_req && !e_dg;
        fout    = e_fg || (pend && !pend_data_port);
        dout    = e_dg || (pend && pend_data_port);

        check_eq("if_gnt", if_gnt, e_fg);
        check_eq("d_gnt", d_gnt, e_dg);
        check_eq("mem_en", mem_en, e_fg || e_dg);
        if (e_fg || e_dg) begin
            check_eq("mem_we", mem_we, e_dg && d_we);
            check_eq("mem_addr", mem_addr, e_dg ? d_addr : if_addr);
            if (e_dg && d_we) check_eq("mem_wdata", mem_wdata, d_wdata);
        end
        check_eq("if_valid", if_valid, e_iv);
        check_eq("d_valid", d_valid, e_dv);
        check_eq("stall_if", stall_if, (if_req && !e_fg) || (fout && !e_iv));
        check_eq("stall_mem", stall_mem, (d_req && !e_dg) || (dout && !e_dv));

        if (e_iv || e_dv) begin
            if (e_iv) exp_if_rdata = pend_data;
            else if (!pend_we) exp_d_rdata = pend_data;
            txn_no++;
            $display("txn %0d cyc %0d %s addr=%0h data=%08h", txn_no, cyc,
                     e_iv ? "fetch" : (pend_we ? "store" : "load"), pend_addr, pend_data);
            pend = 0;
        end
        check_eq("if_rdata", if_rdata, exp_if_rdata);
        check_eq("d_rdata", d_rdata, exp_d_rdata);

        if (e_fg || e_dg) begin
            pend = 1;
            pend_cyc = cyc + LAT + 1;
            free_at = cyc + LAT + 1;
            pend_data_port = e_dg;
            if (e_dg) begin
                pend_we = d_we;
                pend_addr = d_addr;
                if (d_we) begin
                    ref_mem[d_addr] = d_wdata;
                    pend_data = d_wdata;
                end else begin
                    pend_data = ref_mem[d_addr];
                end
            end else begin
                pend_we = 0;
                pend_addr = if_addr;
                pend_data = ref_mem[if_addr];
            end
        end
        if (!if_req || e_fg) fair = 0;
        else if (e_dg && fair < FAIRNESS) fair++;

        last_fg = e_fg; last_dg = e_dg; last_iv = e_iv; last_dv = e_dv; last_rst = 0;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        mem_step();
        obs_if_gnt = if_gnt;
        obs_d_gnt  = d_gnt;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Random requesters: 0 = idle, 1 = requesting, 2 = waiting for valid.
    int f_st = 0, d_st = 0, p_if = 0, p_d = 0;

    task automatic drive_random();
        if (last_rst) begin
            if (f_st == 2) f_st = 0;
            if (d_st == 2) d_st = 0;
        end
        if (f_st == 1 && last_fg) f_st = 2;
        else if (f_st == 2 && last_iv) f_st = 0;
        else if (f_st == 0 && $urandom_range(99) < p_if) begin
            f_st = 1;
            if_addr = ADDR_W'($urandom_range(15));
        end
        if (d_st == 1 && last_dg) d_st = 2;
        else if (d_st == 2 && last_dv) d_st = 0;
        else if (d_st == 0 && $urandom_range(99) < p_d) begin
            d_st = 1;
            d_we = 1'($urandom_range(1));
            d_addr = ADDR_W'($urandom_range(15));
            d_wdata = $urandom;
        end
        if_req = (f_st == 1);
        d_req  = (d_st == 1);
        rst    = ($urandom_range(299) == 0);
    endtask

    logic [7:0] seq;
    int         n_gnt;
    int         probs_if [5] = '{30, 100, 100, 0, 70};
    int         probs_d  [5] = '{30, 100, 0, 100, 20};

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_array[i] = $urandom;
            ref_mem[i]   = mem_array[i];
        end
        mem_array[5] = 32'hDEAD_BEEF;
        ref_mem[5]   = 32'hDEAD_BEEF;
        for (int i = 0; i <= LAT; i++) rd_pipe[i] = '0;
        #1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);

        // Lone fetch from address 5.
        if_req = 1'b1; if_addr = 10'd5;
        cycle();
        if_req = 1'b0;
        idle_cycles(3);
        check_eq("dir_fetch_data", if_rdata, 32'hDEAD_BEEF);
        idle_cycles(1);

        // Simultaneous load and fetch: load first, fetch granted on the load's valid cycle.
        if_req = 1'b1; if_addr = 10'd9;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd8;
        cycle();
        d_req = 1'b0;
        idle_cycles(3);
        if_req = 1'b0;
        idle_cycles(4);

        // Store then load the same word.
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd4; d_wdata = 32'd7;
        cycle();
        d_req = 1'b0;
        idle_cycles(3);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd4;
        cycle();
        d_req = 1'b0;
        idle_cycles(3);
        check_eq("dir_store_load", d_rdata, 32'd7);
        idle_cycles(1);

        // Reset in the middle of a fetch, then a fresh fetch right after.
        if_req = 1'b1; if_addr = 10'd5;
        cycle();
        if_req = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0; if_req = 1'b1; if_addr = 10'd6;
        cycle();
        check_eq("dir_post_rst_gnt", obs_if_gnt, 1);
        if_req = 1'b0;
        idle_cycles(4);

        // Both ports held high: fairness pattern D,D,D,F,D,D,D,F.
        seq = '0; n_gnt = 0;
        if_req = 1'b1; if_addr = 10'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd2;
        for (int i = 0; i < 60 && n_gnt < 8; i++) begin
            cycle();
            if (obs_if_gnt || obs_d_gnt) begin
                seq = {seq[6:0], obs_d_gnt};
                n_gnt++;
            end
        end
        check_eq("fair_grant_count", n_gnt, 8);
        check_eq("fair_sequence", seq, 8'b1110_1110);
        if_req = 1'b0; d_req = 1'b0;
        idle_cycles(5);

        // Randomized traffic in several load mixes.
        for (int ph = 0; ph < 5; ph++) begin
            p_if = probs_if[ph];
            p_d  = probs_d[ph];
            f_st = 0; d_st = 0;
            for (int i = 0; i < 400; i++) begin
                drive_random();
                cycle();
            end
            if_req = 1'b0; d_req = 1'b0; rst = 1'b0;
            idle_cycles(LAT + 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
